// File: rtl/cordic_share_sched.sv
// Round-robin scheduler sharing one pipelined CORDIC cosine unit among NREQ requesters.
// Define CORDIC_SCHED_PERF_EN to add the perf_issued / perf_stall counters.
module cordic_share_sched #(
  parameter int  NREQ    = 4,
  parameter int  LATENCY = 3,
  localparam int IDXW    = $clog2(NREQ)
) (
  input  logic                 clock,
  input  logic                 aclr_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [32*NREQ-1:0]   rsp_data,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic                 cordic_aclr,
  output logic                 cordic_clk_en,
  output logic [31:0]          cordic_dataa,
  input  logic [31:0]          cordic_result
`ifdef CORDIC_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_stall
`endif
);

  logic [LATENCY-1:0] tag_v_reg;
  logic [IDXW-1:0]    tag_idx_reg [LATENCY];
  logic [IDXW-1:0]    rr_ptr_reg;
  logic [NREQ-1:0]    rsp_valid_reg;
  logic [31:0]        rsp_data_reg [NREQ];

  logic            head_v;
  logic [IDXW-1:0] head_idx;
  logic            adv;
  logic            grant_v;
  logic [IDXW-1:0] grant_idx;

  assign head_v   = tag_v_reg[LATENCY-1];
  assign head_idx = tag_idx_reg[LATENCY-1];

  // The only stall source: a finished op whose owner's buffer is full and not draining.
  assign adv = aclr_n & ~(head_v & rsp_valid_reg[head_idx] & ~rsp_ready[head_idx]);

  assign cordic_aclr   = ~aclr_n;
  assign cordic_clk_en = adv;

  always_comb begin
    int              j;
    logic [IDXW-1:0] jj;
    grant_v   = 1'b0;
    grant_idx = '0;
    j         = 0;
    jj        = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr_reg) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IDXW'(j);
      if (adv && !grant_v && req_valid[jj]) begin
        grant_v   = 1'b1;
        grant_idx = jj;
      end
    end
  end

  always_comb begin
    req_ready    = '0;
    cordic_dataa = 32'h0;
    if (grant_v) begin
      req_ready[grant_idx] = 1'b1;
      cordic_dataa         = req_data[32*grant_idx +: 32];
    end
  end

  always_ff @(posedge clock) begin
    if (!aclr_n) begin
      tag_v_reg  <= '0;
      rr_ptr_reg <= '0;
    end else if (adv) begin
      tag_v_reg[0]   <= grant_v;
      tag_idx_reg[0] <= grant_idx;
      for (int k = 1; k < LATENCY; k++) begin
        tag_v_reg[k]   <= tag_v_reg[k-1];
        tag_idx_reg[k] <= tag_idx_reg[k-1];
      end
      if (grant_v)
        rr_ptr_reg <= (grant_idx == IDXW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Capture takes priority over consume so a same-cycle refill keeps valid high with new data.
  always_ff @(posedge clock) begin
    if (!aclr_n) begin
      rsp_valid_reg <= '0;
      for (int i = 0; i < NREQ; i++) rsp_data_reg[i] <= 32'h0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (adv && head_v && head_idx == IDXW'(i)) begin
          rsp_valid_reg[i] <= 1'b1;
          rsp_data_reg[i]  <= cordic_result;
        end else if (rsp_valid_reg[i] && rsp_ready[i]) begin
          rsp_valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rsp
      assign rsp_data[32*gi +: 32] = rsp_data_reg[gi];
    end
  endgenerate

`ifdef CORDIC_SCHED_PERF_EN
  logic [31:0] perf_issued_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clock) begin
    if (!aclr_n) begin
      perf_issued_reg <= 32'h0;
      perf_stall_reg  <= 32'h0;
    end else begin
      if (grant_v) perf_issued_reg <= perf_issued_reg + 32'd1;
      if (!adv)    perf_stall_reg  <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_issued = perf_issued_reg;
  assign perf_stall  = perf_stall_reg;
`endif

endmodule
